// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes
// and the odd-parity helper used when framing a host-to-device byte.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQ      = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_REL = 3'd5,
    ST_DONE     = 3'd6
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // Parity bit that makes data plus parity hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one open-collector PS/2 line plus a falling-edge
// detector on the synchronized value. Flops idle high, matching a released line.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  // Synchronize the raw line and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_meta   <= i_line;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_sync_d & ~r_sync;

endmodule

// File: rtl/ps2_cmd_tx.sv
// Host-to-device PS/2 command transmitter. Inhibits the bus, issues a request
// to send, shifts the byte out on device clock falling edges (LSB first, odd
// parity, stop), samples the device acknowledge and waits for bus release.
// Any stall longer than TIMEOUT_CYCLES aborts the transfer with timeout set.
module ps2_cmd_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout
);

  localparam int IN_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IN_W-1:0] INH_LAST = IN_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t      r_state;
  logic [7:0]      r_data;
  logic [3:0]      r_bit_idx;
  logic [IN_W-1:0] r_inh_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_ack;
  logic            r_clk_oe;
  logic            r_data_oe;
  logic            r_done;
  logic            r_ack_ok;
  logic            r_timeout;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_data_sync;
  logic w_data_fall_unused;
  logic w_accept;
  logic w_to_hit;

  ps2_sync_edge u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_line (ps2_clk_in),
    .o_sync (w_clk_sync),
    .o_fall (w_clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .i_line (ps2_data_in),
    .o_sync (w_data_sync),
    .o_fall (w_data_fall_unused)
  );

  assign w_accept = tx_valid & tx_ready;
  assign w_to_hit = (r_to_cnt == TO_LAST);

  // Transfer sequencer with all bus-facing and status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_data    <= 8'h00;
      r_bit_idx <= 4'd0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_ack     <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_ack_ok  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_done    <= 1'b0;
          r_ack_ok  <= 1'b0;
          r_timeout <= 1'b0;
          if (w_accept) begin
            r_data    <= tx_data;
            r_ack     <= 1'b0;
            r_inh_cnt <= '0;
            r_clk_oe  <= 1'b1;
            r_state   <= ST_INHIBIT;
          end else begin
            r_inh_cnt <= '0;
          end
        end

        ST_INHIBIT: begin
          if (r_inh_cnt == INH_LAST) begin
            // Clock release and start bit happen on the same edge, so the
            // two enables are never asserted together.
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b1;
            r_to_cnt  <= '0;
            r_state   <= ST_REQ;
          end else begin
            r_inh_cnt <= r_inh_cnt + IN_W'(1);
          end
        end

        ST_REQ: begin
          if (w_clk_fall) begin
            r_bit_idx <= 4'd0;
            r_to_cnt  <= '0;
            r_state   <= ST_SHIFT;
          end else if (w_to_hit) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_to_cnt  <= '0;
            r_done    <= 1'b1;
            r_ack_ok  <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        ST_SHIFT: begin
          if (w_clk_fall) begin
            r_to_cnt  <= '0;
            r_bit_idx <= r_bit_idx + 4'd1;
            if (r_bit_idx < 4'd8) begin
              r_data_oe <= ~r_data[r_bit_idx[2:0]];
            end else if (r_bit_idx == 4'd8) begin
              r_data_oe <= ~odd_parity(r_data);
            end else begin
              r_data_oe <= 1'b0;
              r_state   <= ST_ACK;
            end
          end else if (w_to_hit) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_to_cnt  <= '0;
            r_done    <= 1'b1;
            r_ack_ok  <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        ST_ACK: begin
          if (w_clk_fall) begin
            r_ack    <= ~w_data_sync;
            r_to_cnt <= '0;
            r_state  <= ST_WAIT_REL;
          end else if (w_to_hit) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_to_cnt  <= '0;
            r_done    <= 1'b1;
            r_ack_ok  <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        ST_WAIT_REL: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (w_clk_sync && w_data_sync) begin
            r_to_cnt  <= '0;
            r_done    <= 1'b1;
            r_ack_ok  <= r_ack;
            r_timeout <= 1'b0;
            r_state   <= ST_DONE;
          end else if (w_to_hit) begin
            r_to_cnt  <= '0;
            r_done    <= 1'b1;
            r_ack_ok  <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end

        ST_DONE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_done    <= 1'b0;
          r_ack_ok  <= 1'b0;
          r_timeout <= 1'b0;
          r_to_cnt  <= '0;
          r_state   <= ST_IDLE;
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_done    <= 1'b0;
          r_ack_ok  <= 1'b0;
          r_timeout <= 1'b0;
          r_to_cnt  <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign done        = r_done;
  assign ack_ok      = r_ack_ok;
  assign timeout     = r_timeout;

endmodule

// File: doc/ps2_cmd_tx.md
PS2_CMD_TX -- requirements
Module: ps2_cmd_tx

Interface
REQ-001 The block SHALL take these parameters:
- INHIBIT_CYCLES, 10000, clk cycles that PS2 clock is held low before the request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000, maximum clk cycles between consecutive device clock falling edges after the request (20 ms).

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  system clock; one clock.
- rst  in  1  reset; asynchronous, active-high.
- tx_valid  in  1  command byte offered.
- tx_ready  out  1  block can accept a command.
- tx_data  in  8  command byte (e.g. 0xED set-LEDs, 0xFF reset).
- ps2_clk_in  in  1  raw PS2_CLK line state, asynchronous.
- ps2_data_in  in  1  raw PS2_DATA line state, asynchronous.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release.
- ps2_data_oe  out  1  1 = drive PS2_DATA low; 0 = release.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer end.
- ack_ok  out  1  valid with done: device acknowledged.
- timeout  out  1  valid with done: transfer aborted on timeout.

Function
REQ-003 tx_ready SHALL be 1 only in IDLE; a command is accepted when tx_valid && tx_ready, tx_data is latched that cycle, and the FSM enters INHIBIT next cycle.
REQ-004 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a device clock falling edge is synchronized clock 1 -> 0 between consecutive cycles.
REQ-005 The FSM SHALL have these states: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL, DONE.
REQ-006 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
REQ-007 REQ: ps2_data_oe=1 (start bit) and ps2_clk_oe=0; on the first falling edge go to SHIFT with bit index 0.
REQ-008 SHIFT: on falling edges 1..8, present data bits 0..7 LSB first. Falling edge 9 presents odd parity, so the data bits plus parity contain an odd number of ones. Falling edge 10 releases data (stop bit), then go to ACK.
REQ-009 Bit presentation SHALL set ps2_data_oe = ~bit, taking effect the cycle after the synchronized falling edge is detected.
REQ-010 ACK: on the next falling edge, sample synchronized data; 0 sets the ack flag, 1 clears it; then go to WAIT_REL.
REQ-011 WAIT_REL: stay until both synchronized lines read 1, then go to DONE.
REQ-012 DONE: lasts one cycle with done=1, ack_ok = ack flag, timeout=0; then go to IDLE.
REQ-013 From REQ, SHIFT, ACK or WAIT_REL, TIMEOUT_CYCLES cycles without a falling edge (WAIT_REL: without both lines high) SHALL abort the transfer:
- both oe outputs released;
- DONE with timeout=1, ack_ok=0.
REQ-014 The timeout counter SHALL clear on every falling edge and on every state change; its width SHALL be ceil(log2(TIMEOUT_CYCLES+1)).
REQ-015 ps2_clk_oe and ps2_data_oe SHALL never both be 1 outside INHIBIT-to-REQ hand-over; in IDLE, WAIT_REL and DONE both SHALL be 0.
REQ-016 tx_valid while busy SHALL be ignored and SHALL NOT alter the latched byte.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 ack_ok and timeout SHALL be 0 whenever done=0.

Reset
REQ-019 While rst=1, regardless of clk, the block SHALL hold:
- state = IDLE;
- tx_ready=1, busy=0, done=0, ack_ok=0, timeout=0;
- ps2_clk_oe=0, ps2_data_oe=0;
- all counters and synchronizer flops at their idle values (synchronizers = 1).
REQ-020 Reset asserted mid-transfer SHALL release both lines immediately and SHALL produce no done pulse.

Structure
REQ-021 State encodings and the PS/2 command constants (0xED, 0xF4, 0xFF, 0xFA ack byte) SHALL live in a shared ps2_pkg, reused by OperationEncoder.
REQ-022 One sub-module, ps2_sync_edge, SHALL hold the 2-flop synchronizer and falling-edge detector and SHALL be instantiated once per line.

Verification
REQ-023 The bench SHALL model the PS/2 device at 15 kHz, sample data on the rising edge, and cover these directed scenarios:
- tx_data=0xED accepted -> ps2_clk_oe high for 10000 cycles; bits 1,0,1,1,0,1,1,1 then parity 1 and stop seen; device acks -> done with ack_ok=1, timeout=0.
- tx_data=0x00 -> parity bit 1; tx_data=0x01 -> parity bit 0.
- Device holds data high at the ack clock -> done with ack_ok=0, timeout=0.
- Device stops clocking after bit 3 -> after 2000000 cycles done with timeout=1; both oe = 0.
- rst pulsed during SHIFT -> oe outputs 0 within the same cycle, no done, tx_ready=1 after release.
- tx_valid asserted with 0x55 while busy sending 0xFF -> 0xFF transmitted unaltered; 0x55 not latched.
